move_resolver: RTL and testbench
================================

Name: move_resolver

Overview:
- Responder end of the player move-request handshake.
- Accepts one-cycle move requests (target tile plus current key count), reads the target tile from the map BRAM, and applies the game rules for floor, wall, key, door and teleport tiles.
- Returns an accept/reject decision, the final player position and the new key count; writes the tile back when it is consumed.
- Sits between the player movement logic and the shared map BRAM port.

Parameters:
- MAP_BASE, 19'h0, BRAM word address of tile (0,0); tile address = MAP_BASE + {ask_y, ask_x}.
- RD_LAT, 1, BRAM read latency in clk cycles from registered address to valid data (1..3).
- KEY_MAX, 15, saturation value of the key count (must be <= 15).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ask_move  in  1  one-cycle move request strobe
- ask_x  in  4  requested target column
- ask_y  in  4  requested target row
- player_x  in  4  current column; returned on reject
- player_y  in  4  current row; returned on reject
- key_num  in  4  current key count
- busy  out  1  request in progress; ask_move ignored while high
- move_done  out  1  one-cycle pulse, decision ready
- accept_move  out  1  one-cycle pulse together with move_done when the move is accepted
- goto_x  out  4  resolved column, valid from move_done
- goto_y  out  4  resolved row, valid from move_done
- key_num_out  out  4  resolved key count, valid from move_done
- bRAM_map_addr  out  19  map word address
- bRAM_map_data  in  16  map read data; tile id in [3:0], teleport dest x in [15:12], dest y in [11:8]
- bRAM_map_wr  out  1  one-cycle write strobe
- bRAM_map_dwrite  out  16  write data

Behaviour:
- Reset: all outputs 0; FSM to IDLE; latched request cleared. Asserting reset mid-request aborts the request with no write and no pulse.
- FSM states:
  - IDLE: on ask_move, latch ask_x, ask_y, player_x, player_y, key_num; register bRAM_map_addr; go to WAIT. busy goes high from the next cycle.
  - WAIT: down-counter loaded with RD_LAT. When it expires, decode bRAM_map_data combinationally and register the results; go to RESP.
  - RESP: move_done=1, accept_move=decision, optional bRAM_map_wr; next state IDLE. busy drops with the transition out of RESP.
- Latency: ask sampled at edge E; outputs registered at edge E+RD_LAT+1; pulses high for exactly one cycle. The earliest new request is sampled at the edge ending the RESP cycle.
- ask_move while busy is ignored, not queued.
- Tile rules, with t = bRAM_map_data[3:0] and k = latched key count:
  - 0 floor: accept; goto=ask; key_num_out=k; no write.
  - 1 wall: reject; goto=player position; key_num_out=k; no write.
  - 2 key:
    - If k<KEY_MAX: accept; key_num_out=k+1; write {data[15:4],4'h0}.
    - If k==KEY_MAX: accept; key_num_out=k; no write, so the key stays on the map.
  - 3 door:
    - If k>0: accept; key_num_out=k-1; write {data[15:4],4'h0}.
    - If k==0: reject; no write.
  - 4 teleport: see Optional Feature.
  - 5..15 unknown: treated as wall.
- Write: bRAM_map_wr is high in the RESP cycle only. bRAM_map_addr is unchanged (the target tile address) and bRAM_map_dwrite is held stable during that cycle.
- goto_x, goto_y, key_num_out and bRAM_map_addr hold their values until the next decision or request; accept_move and bRAM_map_wr are 0 outside RESP.
- Key arithmetic is 4-bit with no wrap: increment saturates at KEY_MAX; decrement never occurs at 0.

Optional Feature:
- Macro: MOVE_RESOLVER_TELEPORT_EN.
- Defined: tile 4 is accepted with goto_x=data[15:12], goto_y=data[11:8] and key_num_out=k; no write. Destination contents are not checked.
- Undefined: tile 4 is treated as a wall (reject).

Test Plan:
- Floor: RD_LAT=1, map(3,2)=16'h0000, ask (3,2) from (2,2), k=0 -> move_done and accept_move high 2 cycles after ask; goto=(3,2), key_num_out=0, bRAM_map_wr=0.
- Wall: map(5,5)=16'h0001, ask (5,5) from (5,4) -> move_done=1, accept_move=0, goto=(5,4), no write.
- Key pickup and saturation:
  - Map(1,1)=16'hAB02, k=3 -> accept, key_num_out=4, wr=1 with addr=MAP_BASE+8'h11, dwrite=16'hAB00.
  - Repeat with k=15 -> accept, key_num_out=15, no write.
- Door:
  - Map(7,0)=16'h0003, k=0 -> reject, no write.
  - Same tile, k=2 -> accept, key_num_out=1, dwrite=16'h0000.
- Teleport and busy:
  - With MOVE_RESOLVER_TELEPORT_EN, map(4,4)=16'h9A04 -> accept, goto=(9,10).
  - A second ask_move issued one cycle after the first is ignored; exactly one move_done occurs.
- Reset mid-operation: RD_LAT=3, assert rstn low in WAIT -> no move_done, no wr; all outputs 0; a new request after release completes normally.

Source files
------------

// File: rtl/move_resolver_if.sv
// move_resolver_if: move-request handshake between player logic and the resolver,
// plus the resolver's port onto the shared map BRAM.
interface move_resolver_if;
    logic        ask_move;
    logic [3:0]  ask_x;
    logic [3:0]  ask_y;
    logic [3:0]  player_x;
    logic [3:0]  player_y;
    logic [3:0]  key_num;
    logic        busy;
    logic        move_done;
    logic        accept_move;
    logic [3:0]  goto_x;
    logic [3:0]  goto_y;
    logic [3:0]  key_num_out;
    logic [18:0] bRAM_map_addr;
    logic [15:0] bRAM_map_data;
    logic        bRAM_map_wr;
    logic [15:0] bRAM_map_dwrite;

    modport master (
        output ask_move, ask_x, ask_y, player_x, player_y, key_num, bRAM_map_data,
        input  busy, move_done, accept_move, goto_x, goto_y, key_num_out,
               bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
    );

    modport slave (
        input  ask_move, ask_x, ask_y, player_x, player_y, key_num, bRAM_map_data,
        output busy, move_done, accept_move, goto_x, goto_y, key_num_out,
               bRAM_map_addr, bRAM_map_wr, bRAM_map_dwrite
    );
endinterface

// File: rtl/move_resolver.sv
// move_resolver: resolves a player move against the target map tile (floor/wall/key/door).
// Define MOVE_RESOLVER_TELEPORT_EN to make tile 4 a teleport instead of a wall.
module move_resolver #(
    parameter logic [18:0] MAP_BASE = 19'h0,
    parameter int          RD_LAT   = 1,
    parameter int          KEY_MAX  = 15
) (
    input logic           clk,
    input logic           rstn,
    move_resolver_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] KMAX = 4'(KEY_MAX);

    logic [1:0] state, cnt;
    logic [3:0] ax, ay, px, py, k;
    logic [3:0] t, gx, gy, kn;
    logic       is_floor, is_key, is_door, is_tele, take_key, open_door, acc, wr;

    assign t         = bus.bRAM_map_data[3:0];
    assign is_floor  = t == 4'd0;
    assign is_key    = t == 4'd2;
    assign is_door   = t == 4'd3;
`ifdef MOVE_RESOLVER_TELEPORT_EN
    assign is_tele   = t == 4'd4;
`else
    assign is_tele   = 1'b0;
`endif
    assign take_key  = is_key && k < KMAX;
    assign open_door = is_door && k != 4'd0;
    assign acc       = is_floor || is_key || open_door || is_tele;
    assign wr        = take_key || open_door;
    assign gx        = is_tele ? bus.bRAM_map_data[15:12] : acc ? ax : px;
    assign gy        = is_tele ? bus.bRAM_map_data[11:8] : acc ? ay : py;
    assign kn        = take_key ? k + 4'd1 : open_door ? k - 4'd1 : k;
    assign bus.busy  = state != IDLE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            cnt                 <= 2'd0;
            {ax, ay, px, py, k} <= '0;
            bus.move_done       <= 1'b0;
            bus.accept_move     <= 1'b0;
            bus.bRAM_map_wr     <= 1'b0;
            bus.goto_x          <= 4'd0;
            bus.goto_y          <= 4'd0;
            bus.key_num_out     <= 4'd0;
            bus.bRAM_map_addr   <= 19'd0;
            bus.bRAM_map_dwrite <= 16'd0;
        end else begin
            bus.move_done   <= 1'b0;
            bus.accept_move <= 1'b0;
            bus.bRAM_map_wr <= 1'b0;
            // A request may be taken on the edge that ends RESP as well as from IDLE
            if (state != WAIT && bus.ask_move) begin
                ax                <= bus.ask_x;
                ay                <= bus.ask_y;
                px                <= bus.player_x;
                py                <= bus.player_y;
                k                 <= bus.key_num;
                bus.bRAM_map_addr <= MAP_BASE + {11'd0, bus.ask_y, bus.ask_x};
                cnt               <= 2'(RD_LAT);
                state             <= WAIT;
            end else if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    bus.move_done       <= 1'b1;
                    bus.accept_move     <= acc;
                    bus.bRAM_map_wr     <= wr;
                    bus.goto_x          <= gx;
                    bus.goto_y          <= gy;
                    bus.key_num_out     <= kn;
                    bus.bRAM_map_dwrite <= {bus.bRAM_map_data[15:4], 4'h0};
                    state               <= RESP;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_move_resolver.sv
// tb_move_resolver: directed checks of move_resolver with a behavioural map BRAM.
// dut_a runs with RD_LAT=1, dut_b with RD_LAT=3 for the mid-request reset case.
module tb_move_resolver;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] mem [256];
    logic        pk_en = 1'b0;
    logic [7:0]  pk_a = 8'd0;
    logic [15:0] pk_d = 16'd0;
    logic [15:0] rd_a;
    logic [15:0] rd_b [3];

    move_resolver_if ia();
    move_resolver_if ib();

    move_resolver #(.RD_LAT(1)) dut_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
    move_resolver #(.RD_LAT(3)) dut_b (.clk(clk), .rstn(rstn), .bus(ib.slave));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        if (ia.bRAM_map_wr) mem[ia.bRAM_map_addr[7:0]] <= ia.bRAM_map_dwrite;
        if (ib.bRAM_map_wr) mem[ib.bRAM_map_addr[7:0]] <= ib.bRAM_map_dwrite;
        rd_a    <= mem[ia.bRAM_map_addr[7:0]];
        rd_b[0] <= mem[ib.bRAM_map_addr[7:0]];
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign ia.bRAM_map_data = rd_a;
    assign ib.bRAM_map_data = rd_b[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_a = a; pk_d = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic req(input logic [3:0] x, y, px, py, k, output int lat);
        @(negedge clk);
        ia.ask_move = 1'b1; ia.ask_x = x; ia.ask_y = y;
        ia.player_x = px; ia.player_y = py; ia.key_num = k;
        @(negedge clk);
        ia.ask_move = 1'b0;
        lat = 0;
        while (!ia.move_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_resp(input string tag, input int lat, input logic acc,
                               input logic [3:0] gx, gy, kn, input logic wr);
        check({tag, "_lat"}, lat, 2);
        check({tag, "_done"}, ia.move_done, 1'b1);
        check({tag, "_acc"}, ia.accept_move, acc);
        check({tag, "_goto"}, {ia.goto_x, ia.goto_y}, {gx, gy});
        check({tag, "_key"}, ia.key_num_out, kn);
        check({tag, "_wr"}, ia.bRAM_map_wr, wr);
    endtask

    initial begin
        int lat;
        int pulses;
        ia.ask_move = 1'b0; ia.ask_x = 0; ia.ask_y = 0; ia.player_x = 0; ia.player_y = 0; ia.key_num = 0;
        ib.ask_move = 1'b0; ib.ask_x = 0; ib.ask_y = 0; ib.player_x = 0; ib.player_y = 0; ib.key_num = 0;
        #2 rstn = 1'b0;
        @(negedge clk);
        check("rst_outs", {ia.busy, ia.move_done, ia.accept_move, ia.bRAM_map_wr}, 4'h0);
        check("rst_vals", {ia.goto_x, ia.goto_y, ia.key_num_out, ia.bRAM_map_addr, ia.bRAM_map_dwrite}, 0);
        @(negedge clk);
        rstn = 1'b1;

        poke(8'h23, 16'h0000);
        req(4'd3, 4'd2, 4'd2, 4'd2, 4'd0, lat);
        expect_resp("floor", lat, 1'b1, 4'd3, 4'd2, 4'd0, 1'b0);
        @(negedge clk);
        check("floor_pulse", {ia.move_done, ia.accept_move, ia.busy}, 3'b000);

        poke(8'h55, 16'h0001);
        req(4'd5, 4'd5, 4'd5, 4'd4, 4'd2, lat);
        expect_resp("wall", lat, 1'b0, 4'd5, 4'd4, 4'd2, 1'b0);

        poke(8'h11, 16'hAB02);
        req(4'd1, 4'd1, 4'd0, 4'd1, 4'd3, lat);
        expect_resp("key", lat, 1'b1, 4'd1, 4'd1, 4'd4, 1'b1);
        check("key_addr", ia.bRAM_map_addr, 19'h11);
        check("key_dw", ia.bRAM_map_dwrite, 16'hAB00);
        @(negedge clk);
        check("key_mem", mem[8'h11], 16'hAB00);
        check("key_wr_off", ia.bRAM_map_wr, 1'b0);

        poke(8'h11, 16'hAB02);
        req(4'd1, 4'd1, 4'd0, 4'd1, 4'd15, lat);
        expect_resp("keysat", lat, 1'b1, 4'd1, 4'd1, 4'd15, 1'b0);
        @(negedge clk);
        check("keysat_mem", mem[8'h11], 16'hAB02);

        poke(8'h07, 16'h0003);
        req(4'd7, 4'd0, 4'd6, 4'd0, 4'd0, lat);
        expect_resp("door0", lat, 1'b0, 4'd6, 4'd0, 4'd0, 1'b0);
        req(4'd7, 4'd0, 4'd6, 4'd0, 4'd2, lat);
        expect_resp("door2", lat, 1'b1, 4'd7, 4'd0, 4'd1, 1'b1);
        check("door_dw", ia.bRAM_map_dwrite, 16'h0000);
        check("door_addr", ia.bRAM_map_addr, 19'h07);

        poke(8'h44, 16'h9A04);
        req(4'd4, 4'd4, 4'd4, 4'd3, 4'd5, lat);
`ifdef MOVE_RESOLVER_TELEPORT_EN
        expect_resp("tele", lat, 1'b1, 4'd9, 4'd10, 4'd5, 1'b0);
`else
        expect_resp("tele", lat, 1'b0, 4'd4, 4'd3, 4'd5, 1'b0);
`endif

        poke(8'h66, 16'h0007);
        req(4'd6, 4'd6, 4'd6, 4'd5, 4'd1, lat);
        expect_resp("unknown", lat, 1'b0, 4'd6, 4'd5, 4'd1, 1'b0);

        // second strobe while busy must be dropped, not queued
        @(negedge clk);
        ia.ask_move = 1'b1; ia.ask_x = 4'd3; ia.ask_y = 4'd2; ia.player_x = 4'd2; ia.player_y = 4'd2; ia.key_num = 4'd0;
        @(negedge clk);
        check("busy_hi", ia.busy, 1'b1);
        @(negedge clk);
        ia.ask_move = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (ia.move_done) pulses++;
            @(negedge clk);
        end
        check("busy_pulses", pulses, 1);
        check("busy_lo", ia.busy, 1'b0);

        @(negedge clk);
        ib.ask_move = 1'b1; ib.ask_x = 4'd3; ib.ask_y = 4'd2; ib.player_x = 4'd2; ib.player_y = 4'd2; ib.key_num = 4'd0;
        @(negedge clk);
        ib.ask_move = 1'b0;
        @(negedge clk);
        check("b_busy", ib.busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("b_rst_outs", {ib.busy, ib.move_done, ib.accept_move, ib.bRAM_map_wr}, 4'h0);
        check("b_rst_vals", {ib.goto_x, ib.goto_y, ib.key_num_out, ib.bRAM_map_addr}, 0);
        pulses = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (ib.move_done || ib.bRAM_map_wr) pulses++;
            @(negedge clk);
        end
        check("b_abort", pulses, 0);

        ib.ask_move = 1'b1; ib.ask_x = 4'd3; ib.ask_y = 4'd2; ib.player_x = 4'd2; ib.player_y = 4'd2; ib.key_num = 4'd0;
        @(negedge clk);
        ib.ask_move = 1'b0;
        lat = 0;
        while (!ib.move_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b_lat", lat, 4);
        check("b_acc", ib.accept_move, 1'b1);
        check("b_goto", {ib.goto_x, ib.goto_y}, 8'h32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
